// File: rtl/mctrl_pkg.sv
// Shared encodings for the multi-cycle CPU main control FSM: state codes,
// opcode/funct constants, datapath select codes and the per-state control
// payload with its Moore decode helper.
package mctrl_pkg;

  localparam int unsigned STATE_W    = 4;
  localparam int unsigned OP_W       = 6;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned ALU_CTRL_W = 2;
  localparam int unsigned SRCB_W     = 2;
  localparam int unsigned PC_SRC_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_ADDIEX = 4'd11,
    ST_ADDIWB = 4'd12,
    ST_BNE    = 4'd13
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 2'b11;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 2'b10;

  localparam logic [SRCB_W-1:0] SRCB_REG   = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_ONE   = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM   = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_SHIMM = 2'b11;

  localparam logic [PC_SRC_W-1:0] PC_ALU    = 2'b00;
  localparam logic [PC_SRC_W-1:0] PC_ALUOUT = 2'b01;
  localparam logic [PC_SRC_W-1:0] PC_JUMP   = 2'b10;

  // Datapath control payload for one FSM state.
  typedef struct packed {
    logic                  alu_src_a;
    logic [SRCB_W-1:0]     alu_src_b;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  pc_en;
    logic [PC_SRC_W-1:0]   pc_src;
    logic                  i_or_d;
    logic                  mem_write;
    logic                  ir_write;
    logic                  reg_dst;
    logic                  mem_to_reg;
    logic                  reg_write;
  } ctrl_t;

  // Moore decode of a state; exec_alu is the funct-derived op used in EXEC.
  // Conditional branch pc_en is left 0 here and resolved against zero later.
  function automatic ctrl_t state_ctrl(input state_e st,
                                       input logic [ALU_CTRL_W-1:0] exec_alu);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_ONE;
        c.alu_ctrl  = ALU_ADD;
        c.pc_src    = PC_ALU;
        c.pc_en     = 1'b1;
      end
      ST_DECODE: begin
        c.alu_src_b = SRCB_SHIMM;
        c.alu_ctrl  = ALU_ADD;
      end
      ST_MEMADR, ST_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_ctrl  = ALU_ADD;
      end
      ST_MEMRD: c.i_or_d = 1'b1;
      ST_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
      end
      ST_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_ctrl  = exec_alu;
      end
      ST_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      ST_BRANCH, ST_BNE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_ctrl  = ALU_SUB;
        c.pc_src    = PC_ALUOUT;
      end
      ST_JUMP: begin
        c.pc_src = PC_JUMP;
        c.pc_en  = 1'b1;
      end
      ST_ADDIWB: c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mctrl_alu_dec.sv
// R-type funct decoder: maps funct to the ALU operation code and flags
// whether the funct is supported.
//   funct       in  6  IR[5:0]
//   alu_ctrl_c  out 2  ALU operation (add when unsupported)
//   funct_ok_c  out 1  funct is a supported R-type operation
module mctrl_alu_dec
  import mctrl_pkg::*;
(
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_c,
  output logic                  funct_ok_c
);

  // Pure lookup; unsupported functs fall through to add with ok cleared.
  always_comb begin
    alu_ctrl_c = ALU_ADD;
    funct_ok_c = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl_c = ALU_ADD;
      FN_SUB:  alu_ctrl_c = ALU_SUB;
      FN_AND:  alu_ctrl_c = ALU_AND;
      FN_NOR:  alu_ctrl_c = ALU_NOR;
      default: funct_ok_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU. Sequences fetch/decode/execute
// and drives ALU operand selects, ALU op, PC/IR/memory/register enables.
// Optional macro MCTRL_BNE_EN adds the bne instruction (opcode 000101).
//   clk, rst_n            clock, async active-low reset
//   opcode, funct, zero   IR fields and ALU zero flag
//   alu_srcA/B, alu_ctrl  ALU operand selects and operation
//   pc_en, pc_src         PC load enable and source select
//   i_or_d, mem_write     memory address select and write
//   ir_write              IR load
//   reg_dst, mem_to_reg,
//   reg_write             register file controls
//   illegal               sticky unsupported-instruction flag
//   state                 current FSM state (debug)
module multicycle_ctrl
  import mctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OP_W-1:0]       opcode,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic                  zero,
  output logic                  alu_srcA,
  output logic [SRCB_W-1:0]     alu_srcB,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  pc_en,
  output logic [PC_SRC_W-1:0]   pc_src,
  output logic                  i_or_d,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  illegal,
  output logic [STATE_W-1:0]    state
);

  state_e                state_q, state_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic                  illegal_q, illegal_d;
  logic                  beq_q, beq_d;
  logic [ALU_CTRL_W-1:0] dec_alu_c;
  logic                  dec_ok_c;
`ifdef MCTRL_BNE_EN
  logic                  bne_q, bne_d;
`endif

  mctrl_alu_dec u_alu_dec (
    .funct      (funct),
    .alu_ctrl_c (dec_alu_c),
    .funct_ok_c (dec_ok_c)
  );

  // State and registered controls; controls are loaded with the decode of
  // the state being entered so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      beq_q     <= 1'b0;
`ifdef MCTRL_BNE_EN
      bne_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      beq_q     <= beq_d;
`ifdef MCTRL_BNE_EN
      bne_q     <= bne_d;
`endif
    end
  end

  // Next-state logic and control decode of the next state.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (dec_ok_c) begin
              state_d = ST_EXEC;
            end else begin
              state_d   = ST_FETCH;
              illegal_d = 1'b1;
            end
          end
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BRANCH;
`ifdef MCTRL_BNE_EN
          OP_BNE:       state_d = ST_BNE;
`endif
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDIEX;
          default: begin
            state_d   = ST_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_MEMADR: state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  state_d = ST_MEMWB;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_MEMWB, ST_MEMWR, ST_ALUWB, ST_BRANCH, ST_BNE, ST_JUMP, ST_ADDIWB:
                 state_d = ST_FETCH;
      default:   state_d = ST_INIT;
    endcase
    ctrl_d = state_ctrl(state_d, dec_alu_c);
    beq_d  = (state_d == ST_BRANCH);
`ifdef MCTRL_BNE_EN
    bne_d  = (state_d == ST_BNE);
`endif
  end

  // Branch PC load follows zero combinationally within the branch cycle.
`ifdef MCTRL_BNE_EN
  assign pc_en = ctrl_q.pc_en | (beq_q & zero) | (bne_q & ~zero);
`else
  assign pc_en = ctrl_q.pc_en | (beq_q & zero);
`endif

  assign alu_srcA   = ctrl_q.alu_src_a;
  assign alu_srcB   = ctrl_q.alu_src_b;
  assign alu_ctrl   = ctrl_q.alu_ctrl;
  assign pc_src     = ctrl_q.pc_src;
  assign i_or_d     = ctrl_q.i_or_d;
  assign mem_write  = ctrl_q.mem_write;
  assign ir_write   = ctrl_q.ir_write;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign illegal    = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl. Outputs are sampled on
// the falling clock edge; inputs change there too, away from the rising edge.
module tb_multicycle_ctrl;
  import mctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       alu_srcA;
  logic [1:0] alu_srcB;
  logic [1:0] alu_ctrl;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       i_or_d;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal;
  logic [3:0] state;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .alu_srcA   (alu_srcA),
    .alu_srcB   (alu_srcB),
    .alu_ctrl   (alu_ctrl),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .i_or_d     (i_or_d),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal    (illegal),
    .state      (state)
  );

  // Field order: srcA, srcB[2], alu_ctrl[2], pc_en, pc_src[2], i_or_d,
  // mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal
  logic [14:0] obs;
  assign obs = {alu_srcA, alu_srcB, alu_ctrl, pc_en, pc_src, i_or_d,
                mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal};

  localparam logic [14:0] V_ZERO    = 15'b0_00_00_0_00_0_0_0_0_0_0_0;
  localparam logic [14:0] V_FETCH   = 15'b0_01_00_1_00_0_0_1_0_0_0_0;
  localparam logic [14:0] V_DECODE  = 15'b0_11_00_0_00_0_0_0_0_0_0_0;
  localparam logic [14:0] V_MEMADR  = 15'b1_10_00_0_00_0_0_0_0_0_0_0;
  localparam logic [14:0] V_MEMRD   = 15'b0_00_00_0_00_1_0_0_0_0_0_0;
  localparam logic [14:0] V_MEMWB   = 15'b0_00_00_0_00_0_0_0_0_1_1_0;
  localparam logic [14:0] V_MEMWR   = 15'b0_00_00_0_00_1_1_0_0_0_0_0;
  localparam logic [14:0] V_EXECSUB = 15'b1_00_01_0_00_0_0_0_0_0_0_0;
  localparam logic [14:0] V_ALUWB   = 15'b0_00_00_0_00_0_0_0_1_0_1_0;
  localparam logic [14:0] V_BR_T    = 15'b1_00_01_1_01_0_0_0_0_0_0_0;
  localparam logic [14:0] V_BR_NT   = 15'b1_00_01_0_01_0_0_0_0_0_0_0;
  localparam logic [14:0] V_JUMP    = 15'b0_00_00_1_10_0_0_0_0_0_0_0;
  localparam logic [14:0] V_ADDIWB  = 15'b0_00_00_0_00_0_0_0_0_0_1_0;
  localparam logic [14:0] ILL       = 15'b0_00_00_0_00_0_0_0_0_0_0_1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_st(input string tag, input logic [3:0] st,
                           input logic [14:0] v);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".ctrl"},  32'(obs),   32'(v));
  endtask

  task automatic at_neg(input string tag, input logic [3:0] st,
                        input logic [14:0] v);
    @(negedge clk);
    expect_st(tag, st, v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; opcode = OP_LW; funct = 6'b0; zero = 1'b0;
    repeat (2) @(posedge clk);
    at_neg("reset", ST_INIT, V_ZERO);
    @(posedge clk); #1 rst_n = 1'b1;

    // lw: 5 cycles FETCH..FETCH
    at_neg("lw.init",   ST_INIT,   V_ZERO);
    at_neg("lw.fetch",  ST_FETCH,  V_FETCH);
    at_neg("lw.decode", ST_DECODE, V_DECODE);
    at_neg("lw.memadr", ST_MEMADR, V_MEMADR);
    at_neg("lw.memrd",  ST_MEMRD,  V_MEMRD);
    at_neg("lw.memwb",  ST_MEMWB,  V_MEMWB);
    at_neg("lw.fetch2", ST_FETCH,  V_FETCH);

    // R-type sub
    opcode = OP_RTYPE; funct = FN_SUB;
    at_neg("sub.decode", ST_DECODE, V_DECODE);
    at_neg("sub.exec",   ST_EXEC,   V_EXECSUB);
    at_neg("sub.aluwb",  ST_ALUWB,  V_ALUWB);
    at_neg("sub.fetch",  ST_FETCH,  V_FETCH);

    // beq taken, then not taken
    opcode = OP_BEQ; zero = 1'b1;
    at_neg("beqt.decode", ST_DECODE, V_DECODE);
    at_neg("beqt.branch", ST_BRANCH, V_BR_T);
    at_neg("beqt.fetch",  ST_FETCH,  V_FETCH);
    zero = 1'b0;
    at_neg("beqn.decode", ST_DECODE, V_DECODE);
    at_neg("beqn.branch", ST_BRANCH, V_BR_NT);
    at_neg("beqn.fetch",  ST_FETCH,  V_FETCH);

    // j
    opcode = OP_J;
    at_neg("j.decode", ST_DECODE, V_DECODE);
    at_neg("j.jump",   ST_JUMP,   V_JUMP);
    at_neg("j.fetch",  ST_FETCH,  V_FETCH);

    // addi
    opcode = OP_ADDI;
    at_neg("addi.decode", ST_DECODE, V_DECODE);
    at_neg("addi.ex",     ST_ADDIEX, V_MEMADR);
    at_neg("addi.wb",     ST_ADDIWB, V_ADDIWB);
    at_neg("addi.fetch",  ST_FETCH,  V_FETCH);

    // unsupported funct sets illegal, then unsupported opcode keeps it
    opcode = OP_RTYPE; funct = 6'b101010;
    at_neg("badfn.decode", ST_DECODE, V_DECODE);
    at_neg("badfn.fetch",  ST_FETCH,  V_FETCH | ILL);
    opcode = 6'b111111;
    at_neg("badop.decode", ST_DECODE, V_DECODE | ILL);
    at_neg("badop.fetch",  ST_FETCH,  V_FETCH | ILL);

    // sw aborted by reset during MEMADR
    opcode = OP_SW;
    at_neg("swr.decode", ST_DECODE, V_DECODE | ILL);
    at_neg("swr.memadr", ST_MEMADR, V_MEMADR | ILL);
    #2 rst_n = 1'b0;
    #1 expect_st("swr.async", ST_INIT, V_ZERO);
    at_neg("swr.held", ST_INIT, V_ZERO);
    @(posedge clk); #1 rst_n = 1'b1;
    at_neg("sw.init",   ST_INIT,   V_ZERO);
    at_neg("sw.fetch",  ST_FETCH,  V_FETCH);
    at_neg("sw.decode", ST_DECODE, V_DECODE);
    at_neg("sw.memadr", ST_MEMADR, V_MEMADR);
    at_neg("sw.memwr",  ST_MEMWR,  V_MEMWR);
    at_neg("sw.fetch2", ST_FETCH,  V_FETCH);

    // bne opcode with zero=0
    opcode = OP_BNE; zero = 1'b0;
    at_neg("bne.decode", ST_DECODE, V_DECODE);
`ifdef MCTRL_BNE_EN
    at_neg("bne.branch", ST_BNE,   V_BR_T);
    at_neg("bne.fetch",  ST_FETCH, V_FETCH);
`else
    at_neg("bne.fetch",  ST_FETCH, V_FETCH | ILL);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM of the multi-cycle CPU. It decodes the instruction opcode and funct fields and produces, cycle by cycle, the datapath controls:
- ALU operand selects and the ALU operation code, which drive the ALU wrapper;
- PC, IR, memory and register-file enables.

It consumes the ALU `zero` flag to resolve branches. It is the driver side of the ALU control interface (alu_srcA / alu_srcB / alu_ctrl).

## Interface
Parameters:
- none (encodings live in `mctrl_pkg`)

Ports (clock, reset first). One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  6  IR[31:26], valid while IR is held
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU result-is-zero flag (combinational from ALU)
- `alu_srcA`  out  1  1 = register A, 0 = PC
- `alu_srcB`  out  2  00 = reg B, 01 = constant 1, 10 = sign-extended imm, 11 = shifted imm
- `alu_ctrl`  out  2  00 = add, 01 = sub, 11 = and, 10 = nor
- `pc_en`  out  1  PC load enable
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write`  out  1  data memory write
- `ir_write`  out  1  IR load
- `reg_dst`  out  1  1 = rd, 0 = rt
- `mem_to_reg`  out  1  1 = MDR, 0 = ALUOut
- `reg_write`  out  1  register file write
- `illegal`  out  1  sticky unsupported-instruction flag
- `state`  out  4  current state (debug)

## Operation
Moore FSM. All outputs decode from `state`, except `pc_en`, which also uses `zero`.

Outputs not listed for a state are 0 in that state.

States and transitions:
- **INIT**: outputs all 0 → FETCH.
- **FETCH**: i_or_d=0, ir_write=1, alu_srcA=0, alu_srcB=01, alu_ctrl=00, pc_src=00, pc_en=1 → DECODE.
- **DECODE**: alu_srcA=0, alu_srcB=11, alu_ctrl=00 (branch target into ALUOut). Next state by opcode:
  - 000000 → EXEC (only if funct is supported; otherwise treated as illegal)
  - 100011 / 101011 → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDIEX
  - anything else → illegal=1, FETCH
- **MEMADR**: alu_srcA=1, alu_srcB=10, alu_ctrl=00 → MEMRD if lw, MEMWR if sw.
- **MEMRD**: i_or_d=1 → MEMWB.
- **MEMWB**: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- **MEMWR**: i_or_d=1, mem_write=1 → FETCH.
- **EXEC**: alu_srcA=1, alu_srcB=00, alu_ctrl from funct:
  - 100000 → 00
  - 100010 → 01
  - 100100 → 11
  - 100111 → 10
  
  → ALUWB.
- **ALUWB**: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- **BRANCH**: alu_srcA=1, alu_srcB=00, alu_ctrl=01, pc_src=01, pc_en=zero → FETCH.
- **JUMP**: pc_src=10, pc_en=1 → FETCH.
- **ADDIEX**: alu_srcA=1, alu_srcB=10, alu_ctrl=00 → ADDIWB.
- **ADDIWB**: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.

`illegal` rules:
- Set on the DECODE→FETCH transition for an unsupported opcode or R-type funct.
- Remains 1 until reset.
- The instruction is skipped: no write enables are asserted.

## Timing
- Reset (rst_n low): `state`=INIT, `illegal`=0, all outputs 0, asynchronously. The first FETCH occurs in the second cycle after rst_n deasserts.
- Cycles per instruction, counted FETCH to the return to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- `zero` is sampled combinationally in BRANCH only. It must settle within that cycle.
- `opcode` and `funct` must be stable from DECODE until the next FETCH. IR changes only at the end of FETCH.
- Reset asserted mid-instruction: the FSM aborts immediately. No write enable may be asserted in the cycle after rst_n falls.

## Configuration
- `MCTRL_BNE_EN` defined: opcode 000101 decodes to state BNE. BNE has the same outputs as BRANCH, except pc_en = ~zero. BNE → FETCH, 3 cycles.
- `MCTRL_BNE_EN` undefined: 000101 is illegal.

## Structure
- `mctrl_pkg` holds:
  - the state encoding (4-bit localparams);
  - opcode and funct constants;
  - alu_ctrl, alu_srcB and pc_src codes.
- Sub-module `mctrl_alu_dec`: combinational funct → {alu_ctrl, funct_ok}. It is used in EXEC and in DECODE legality checking.

## Test plan
- Reset release, opcode=100011 (lw) → states INIT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH.
  - MEMWB has reg_write=1, mem_to_reg=1.
  - pc_en=1 only in FETCH.
- R-type, funct=100010 → EXEC with alu_ctrl=01, alu_srcA=1, alu_srcB=00. Then ALUWB with reg_dst=1, reg_write=1.
- beq (000100) with zero=1 → BRANCH has pc_en=1, pc_src=01. Repeat with zero=0 → pc_en=0.
- opcode=111111, then funct=101010 with opcode 000000 → illegal rises after DECODE. No reg_write or mem_write is asserted. The next FETCH follows.
- sw, with rst_n pulsed low during MEMADR → outputs 0 and state=INIT immediately. mem_write is never asserted. Normal fetch resumes after release.
- With `MCTRL_BNE_EN`: 000101 with zero=0 → pc_en=1. Without the macro → illegal=1.
